timer_sequencer: RTL and testbench

//  Upstream controller for the Timer block. Holds a small table of phase durations and drives
//  the Timer's n_i/start_i. Advances one phase per Timer end pulse (curr_end_q).

---
 rtl/timer_seq_pkg.sv | 19 +
 rtl/timer_seq_table.sv | 34 +++
 rtl/timer_sequencer.sv | 154 +++++++++++++++
 tb/tb_timer_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_seq_pkg.sv
// Shared types and helpers for the timer sequencer.
// Holds the default duration width, the FSM encoding and the clamp-to-1 helper.
package timer_seq_pkg;

   localparam int SEQ_TIME_W = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // A stored duration of 0 would stall the Timer, so it becomes 1.
   function automatic logic [SEQ_TIME_W-1:0] clamp_one(
      input logic [SEQ_TIME_W-1:0] d
   );
      return (d == '0) ? SEQ_TIME_W'(1) : d;
   endfunction

endpackage

// File: rtl/timer_seq_table.sv
// Phase duration table: DEPTH x TIME_W registers, reset to 1.
// One synchronous write port, one combinational read port.
module timer_seq_table
   import timer_seq_pkg::*;
#(
   parameter int TIME_W = SEQ_TIME_W,
   parameter int DEPTH  = 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [TIME_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [TIME_W-1:0] rdata
);

   logic [TIME_W-1:0] mem [DEPTH];

   // Entries reset to 1; writes store the clamped duration.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= TIME_W'(1);
         end
      end else if (we) begin
         mem[waddr] <= clamp_one(wdata);
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/timer_sequencer.sv
// Timer sequencer: steps through a table of phase durations, one per Timer end pulse.
// Build option TIMER_SEQ_LOOP_EN adds loop_i to repeat the sequence until abort.
module timer_sequencer
   import timer_seq_pkg::*;
#(
   parameter int TIME_W = SEQ_TIME_W,
   parameter int DEPTH  = 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we_i,
   input  logic [AW-1:0]     cfg_addr_i,
   input  logic [TIME_W-1:0] cfg_data_i,
   input  logic [AW:0]       cfg_len_i,
   input  logic              go_i,
   input  logic              abort_i,
   input  logic              timer_end_i,
`ifdef TIMER_SEQ_LOOP_EN
   input  logic              loop_i,
`endif
   output logic [TIME_W-1:0] n_q,
   output logic              start_q,
   output logic [AW-1:0]     phase_q,
   output logic              busy_q,
   output logic              done_q
);

   state_t            state_q;
   state_t            state_nx;
   logic [AW:0]       len_q;
   logic [AW:0]       len_nx;
   logic [AW-1:0]     phase_nx;
   logic [AW-1:0]     rd_addr;
   logic [TIME_W-1:0] n_nx;
   logic [TIME_W-1:0] rd_data;
   logic              start_nx;
   logic              busy_nx;
   logic              done_nx;
   logic              len_ok;
   logic              go_ok;
   logic              last;
   logic              loop;
   logic              tbl_we;

`ifdef TIMER_SEQ_LOOP_EN
   assign loop = loop_i;
`else
   assign loop = 1'b0;
`endif

   assign len_ok = (cfg_len_i != '0) && (cfg_len_i <= (AW+1)'(DEPTH));
   assign go_ok  = go_i && len_ok && (state_q == IDLE);
   assign last   = ({1'b0, phase_q} == (len_q - 1'b1));
   assign tbl_we = cfg_we_i && !busy_q;

   timer_seq_table #(
      .TIME_W (TIME_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_table (
      .clk   (clk),
      .rst   (rst),
      .we    (tbl_we),
      .waddr (cfg_addr_i),
      .wdata (cfg_data_i),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   // Read entry 0 for a new (or repeated) pass, else the next phase.
   always_comb begin
      rd_addr = '0;
      if ((state_q == RUN) && !last) begin
         rd_addr = phase_q + 1'b1;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         phase_q <= '0;
         n_q     <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_nx;
         len_q   <= len_nx;
         phase_q <= phase_nx;
         n_q     <= n_nx;
         start_q <= start_nx;
         busy_q  <= busy_nx;
         done_q  <= done_nx;
      end
   end

   // Next state: abort beats a coincident end pulse.
   always_comb begin
      state_nx = state_q;
      unique case (state_q)
         IDLE: begin
            if (go_ok) begin
               state_nx = RUN;
            end
         end
         RUN: begin
            if (abort_i) begin
               state_nx = IDLE;
            end else if (timer_end_i && last && !loop) begin
               state_nx = IDLE;
            end
         end
      endcase
   end

   // Next output values: phase stepping, duration load, done pulse.
   always_comb begin
      len_nx   = len_q;
      phase_nx = phase_q;
      n_nx     = n_q;
      done_nx  = 1'b0;
      start_nx = (state_nx == RUN);
      busy_nx  = (state_nx == RUN);
      unique case (state_q)
         IDLE: begin
            if (go_ok) begin
               phase_nx = '0;
               n_nx     = rd_data;
               len_nx   = cfg_len_i;
            end
         end
         RUN: begin
            if (abort_i) begin
               phase_nx = '0;
            end else if (timer_end_i) begin
               if (!last) begin
                  phase_nx = phase_q + 1'b1;
                  n_nx     = rd_data;
               end else begin
                  phase_nx = '0;
                  done_nx  = 1'b1;
                  if (loop) begin
                     n_nx = rd_data;
                  end
               end
            end
         end
      endcase
   end

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer driven by a behavioural Timer.
// Loop checks are compiled when TIMER_SEQ_LOOP_EN is defined.
module tb_timer_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [15:0] cfg_data;
   logic [3:0]  cfg_len;
   logic        go;
   logic        abort;
   logic [15:0] n_q;
   logic        start_q;
   logic [2:0]  phase_q;
   logic        busy_q;
   logic        done_q;
`ifdef TIMER_SEQ_LOOP_EN
   logic        loop;
`endif

   logic [15:0] tmr_time;
   logic        tmr_end;

   int errs   = 0;
   int checks = 0;

   int start_cnt = 0;
   int done_cnt  = 0;
   int end_cnt   = 0;
   int viol      = 0;
   int nq[$];

   always #5 clk = ~clk;

   timer_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we_i    (cfg_we),
      .cfg_addr_i  (cfg_addr),
      .cfg_data_i  (cfg_data),
      .cfg_len_i   (cfg_len),
      .go_i        (go),
      .abort_i     (abort),
      .timer_end_i (tmr_end),
`ifdef TIMER_SEQ_LOOP_EN
      .loop_i      (loop),
`endif
      .n_q         (n_q),
      .start_q     (start_q),
      .phase_q     (phase_q),
      .busy_q      (busy_q),
      .done_q      (done_q)
   );

   // Timer: N counting cycles (time 0..N-1), then a dead cycle with time=0, end=1.
   always @(posedge clk) begin
      if (rst || !start_q) begin
         tmr_time <= '0;
         tmr_end  <= 1'b0;
      end else if (tmr_end) begin
         tmr_time <= '0;
         tmr_end  <= 1'b0;
      end else if (tmr_time == n_q - 16'd1) begin
         tmr_time <= '0;
         tmr_end  <= 1'b1;
      end else begin
         tmr_time <= tmr_time + 16'd1;
      end
   end

   // Activity monitor: counters only ever increase; tests take deltas.
   always @(negedge clk) begin
      if (start_q) begin
         start_cnt++;
         if (nq.size() == 0 || nq[nq.size()-1] != int'(n_q)) nq.push_back(int'(n_q));
         if (tmr_time >= n_q) viol++;
      end
      if (done_q) done_cnt++;
      if (tmr_end) end_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic launch(input logic [3:0] len);
      @(negedge clk);
      go = 1'b1; cfg_len = len;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      for (int i = 1; i <= 200; i++) begin
         if (done_q) begin
            cyc = i;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   int s0, d0, e0, v0, q0, cyc, found, drops, dn;

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      cfg_len = '0; go = 1'b0; abort = 1'b0;
`ifdef TIMER_SEQ_LOOP_EN
      loop = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_n", 32'(n_q), 0);
      chk("rst_start", 32'(start_q), 0);
      chk("rst_busy", 32'(busy_q), 0);
      chk("rst_done", 32'(done_q), 0);
      chk("rst_phase", 32'(phase_q), 0);
      rst = 1'b0;

      // Three phases {5,3,4}: 15 run cycles, done in cycle 16.
      wr(3'd0, 16'd5); wr(3'd1, 16'd3); wr(3'd2, 16'd4);
      s0 = start_cnt; d0 = done_cnt; v0 = viol; q0 = nq.size();
      launch(4'd3);
      chk("seq_first_n", 32'(n_q), 5);
      chk("seq_busy", 32'(busy_q), 1);
      wait_done(cyc);
      chk("seq_done_cycle", 32'(cyc), 16);
      chk("seq_n_held", 32'(n_q), 4);
      chk("seq_busy_end", 32'(busy_q), 0);
      idle(3);
      chk("seq_start_cycles", 32'(start_cnt - s0), 15);
      chk("seq_done_count", 32'(done_cnt - d0), 1);
      chk("seq_n_steps", 32'(nq.size() - q0), 3);
      if (nq.size() - q0 == 3) begin
         chk("seq_n0", 32'(nq[q0]), 5);
         chk("seq_n1", 32'(nq[q0+1]), 3);
         chk("seq_n2", 32'(nq[q0+2]), 4);
      end
      chk("seq_timer_lt_n", 32'(viol - v0), 0);

      // Zero duration is stored as 1.
      wr(3'd0, 16'd0);
      s0 = start_cnt; d0 = done_cnt; e0 = end_cnt;
      launch(4'd1);
      chk("zero_n", 32'(n_q), 1);
      wait_done(cyc);
      chk("zero_done_cycle", 32'(cyc), 3);
      idle(3);
      chk("zero_start_cycles", 32'(start_cnt - s0), 2);
      chk("zero_end_count", 32'(end_cnt - e0), 1);
      chk("zero_done_count", 32'(done_cnt - d0), 1);

      // Illegal lengths are ignored.
      launch(4'd0);
      idle(1);
      chk("len0_busy", 32'(busy_q), 0);
      launch(4'd9);
      idle(1);
      chk("len9_busy", 32'(busy_q), 0);
      chk("len9_start", 32'(start_q), 0);

      // go and cfg_we during a {5,5} run have no effect.
      wr(3'd0, 16'd5); wr(3'd1, 16'd5);
      s0 = start_cnt; d0 = done_cnt;
      launch(4'd2);
      found = 0;
      for (int i = 0; i < 50; i++) begin
         if (phase_q == 3'd1) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      chk("busy_reach_ph1", 32'(found), 1);
      go = 1'b1; cfg_len = 4'd1; cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 16'd9;
      @(negedge clk);
      go = 1'b0; cfg_we = 1'b0;
      chk("busy_go_phase", 32'(phase_q), 1);
      chk("busy_go_busy", 32'(busy_q), 1);
      wait_done(cyc);
      chk("busy_done_seen", 32'(cyc != 0), 1);
      idle(3);
      chk("busy_start_cycles", 32'(start_cnt - s0), 12);
      chk("busy_done_count", 32'(done_cnt - d0), 1);

      // Abort in phase 1 coincident with the end pulse.
      d0 = done_cnt;
      launch(4'd2);
      found = 0;
      for (int i = 0; i < 50; i++) begin
         if (phase_q == 3'd1 && tmr_end) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      chk("abort_reach", 32'(found), 1);
      chk("abort_readback_n", 32'(n_q), 5);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_start", 32'(start_q), 0);
      chk("abort_busy", 32'(busy_q), 0);
      chk("abort_phase", 32'(phase_q), 0);
      chk("abort_done", 32'(done_q), 0);
      idle(3);
      chk("abort_no_done", 32'(done_cnt - d0), 0);

      // Write and go together: go sees the old entry 0.
      @(negedge clk);
      go = 1'b1; cfg_len = 4'd1; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 16'd7;
      @(negedge clk);
      go = 1'b0; cfg_we = 1'b0;
      chk("same_cycle_old_n", 32'(n_q), 5);
      wait_done(cyc);
      chk("same_cycle_done", 32'(cyc != 0), 1);
      idle(2);
      launch(4'd1);
      chk("same_cycle_new_n", 32'(n_q), 7);
      wait_done(cyc);
      idle(2);

`ifdef TIMER_SEQ_LOOP_EN
      // Loop {2,3}: three passes of 7 cycles, start held, then clean exit.
      wr(3'd0, 16'd2); wr(3'd1, 16'd3);
      s0 = start_cnt;
      loop = 1'b1;
      launch(4'd2);
      drops = 0; dn = 0; found = 0;
      for (int i = 0; i < 200; i++) begin
         if (done_q) dn++;
         if (dn == 2) loop = 1'b0;
         if (!busy_q) begin
            found = 1;
            break;
         end
         if (!start_q) drops++;
         @(negedge clk);
      end
      chk("loop_ended", 32'(found), 1);
      chk("loop_done_pulses", 32'(dn), 3);
      chk("loop_start_drops", 32'(drops), 0);
      chk("loop_start_cycles", 32'(start_cnt - s0), 21);
      chk("loop_start_end", 32'(start_q), 0);
      idle(2);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
